// File: rtl/seg7_scan_reader.sv
// Recovers a 4-digit hex value by sniffing a multiplexed active-low 7-segment display bus.
// A digit is sampled once per stable dwell; a frame completes when all four digits are captured.
module seg7_scan_reader #(
  parameter int unsigned SETTLE  = 4,
  parameter logic [23:0] TIMEOUT = 24'd1_000_000
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic [6:0]  seg_in,
  input  logic [3:0]  an_in,
  output logic [15:0] value,
  output logic        frame_valid,
  output logic        bad_pattern,
  output logic        multi_an_err,
  output logic        stale
);

  localparam int unsigned CNT_W     = 8;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 2);

  typedef enum logic [1:0] {ST_WAIT, ST_SETTLING, ST_HELD} state_t;

  state_t             state_q, state_d;
  logic [6:0]         seg_s1_q, seg_s2_q, seg_p_q;
  logic [3:0]         an_s1_q, an_s2_q, an_p_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [23:0]        to_q, to_d;
  logic [3:0]         seen_q, seen_d, seen_base_c;
  logic [15:0]        shadow_q, shadow_d, value_q, value_d;
  logic               fv_q, fv_d, bad_q, bad_d, multi_q, multi_d, stale_q;
  logic               changed_c, single_c, multi_c, prev_multi_c, sample_c;
  logic               legal_c;
  logic [3:0]         nib_c;
  logic [1:0]         idx_c;

  // Input synchronizers plus one-cycle history for change detection
  always_ff @(posedge clk_in) begin
    if (rst) begin
      seg_s1_q <= 7'h7F;
      seg_s2_q <= 7'h7F;
      seg_p_q  <= 7'h7F;
      an_s1_q  <= 4'hF;
      an_s2_q  <= 4'hF;
      an_p_q   <= 4'hF;
    end else begin
      seg_s1_q <= seg_in;
      seg_s2_q <= seg_s1_q;
      seg_p_q  <= seg_s2_q;
      an_s1_q  <= an_in;
      an_s2_q  <= an_s1_q;
      an_p_q   <= an_s2_q;
    end
  end

  assign changed_c    = (seg_s2_q != seg_p_q) || (an_s2_q != an_p_q);
  assign single_c     = (an_s2_q == 4'b1110) || (an_s2_q == 4'b1101) ||
                        (an_s2_q == 4'b1011) || (an_s2_q == 4'b0111);
  assign multi_c      = !single_c && (an_s2_q != 4'b1111);
  assign prev_multi_c = (an_p_q != 4'b1111) && (an_p_q != 4'b1110) && (an_p_q != 4'b1101) &&
                        (an_p_q != 4'b1011) && (an_p_q != 4'b0111);

  always_comb begin
    idx_c = 2'd0;
    case (an_s2_q)
      4'b1101: idx_c = 2'd1;
      4'b1011: idx_c = 2'd2;
      4'b0111: idx_c = 2'd3;
      default: idx_c = 2'd0;
    endcase
  end

  // Active-low glyph to nibble
  always_comb begin
    legal_c = 1'b1;
    nib_c   = 4'h0;
    case (seg_s2_q)
      7'b1000000: nib_c = 4'h0;
      7'b1111001: nib_c = 4'h1;
      7'b0100100: nib_c = 4'h2;
      7'b0110000: nib_c = 4'h3;
      7'b0011001: nib_c = 4'h4;
      7'b0010010: nib_c = 4'h5;
      7'b0000010: nib_c = 4'h6;
      7'b1111000: nib_c = 4'h7;
      7'b0000000: nib_c = 4'h8;
      7'b0010000: nib_c = 4'h9;
      7'b0001000: nib_c = 4'hA;
      7'b0000011: nib_c = 4'hB;
      7'b1000110: nib_c = 4'hC;
      7'b0100001: nib_c = 4'hD;
      7'b0000110: nib_c = 4'hE;
      7'b0001110: nib_c = 4'hF;
      default:    legal_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q <= ST_WAIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Dwell tracking: one sample after SETTLE stable cycles
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sample_c = 1'b0;
    if (changed_c) begin
      cnt_d   = '0;
      state_d = single_c ? ST_SETTLING : ST_WAIT;
    end else if (state_q == ST_SETTLING) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == SETTLE_LAST) begin
        sample_c = 1'b1;
        state_d  = ST_HELD;
      end
    end
  end

  // Frame assembly, error pulses and timeout
  always_comb begin
    seen_base_c = (to_q == TIMEOUT - 24'd1) ? 4'b0000 : seen_q;
    seen_d      = seen_base_c;
    shadow_d    = shadow_q;
    value_d     = value_q;
    fv_d        = 1'b0;
    bad_d       = 1'b0;
    multi_d     = changed_c && multi_c && !prev_multi_c;
    to_d        = (to_q == TIMEOUT) ? to_q : to_q + 24'd1;
    if (sample_c) begin
      if (legal_c) begin
        shadow_d[{idx_c, 2'b00} +: 4] = nib_c;
        seen_d = seen_base_c | (4'b0001 << idx_c);
        if (seen_d == 4'b1111) begin
          value_d = shadow_d;
          fv_d    = 1'b1;
          seen_d  = 4'b0000;
          to_d    = '0;
        end
      end else begin
        bad_d  = 1'b1;
        seen_d = seen_base_c & ~(4'b0001 << idx_c);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      to_q     <= '0;
      seen_q   <= '0;
      shadow_q <= '0;
      value_q  <= '0;
      fv_q     <= 1'b0;
      bad_q    <= 1'b0;
      multi_q  <= 1'b0;
      stale_q  <= 1'b0;
    end else begin
      to_q     <= to_d;
      seen_q   <= seen_d;
      shadow_q <= shadow_d;
      value_q  <= value_d;
      fv_q     <= fv_d;
      bad_q    <= bad_d;
      multi_q  <= multi_d;
      stale_q  <= (to_q == TIMEOUT);
    end
  end

  assign value        = value_q;
  assign frame_valid  = fv_q;
  assign bad_pattern  = bad_q;
  assign multi_an_err = multi_q;
  assign stale        = stale_q;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Randomized and directed scan stimulus against a dwell-level reference model with an event scoreboard.
module tb_seg7_scan_reader;

  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 100;
  localparam int K_FRAME = 0;
  localparam int K_BAD   = 1;
  localparam int K_MULTI = 2;

  typedef struct {
    int          kind;
    logic [15:0] val;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [6:0]  seg = 7'h7F;
  logic [3:0]  an  = 4'hF;
  logic [15:0] value;
  logic        fv, bp, me, stale;

  int total = 0;
  int bad_cnt = 0;
  int n_frames = 0, n_bad = 0, n_multi = 0;
  logic [15:0] last_val = '0;
  logic fv_prev = 1'b0, bp_prev = 1'b0, me_prev = 1'b0;
  logic stale_at_fv = 1'b0, stale_after_fv = 1'b0;
  ev_t exp_q[$];

  // Reference model state: one entry per digit, updated per dwell
  logic [6:0] glyph [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                             7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  logic [3:0] m_shadow [4];
  logic       m_seen [4];
  logic [3:0] m_prev_an = 4'hF;
  logic [6:0] m_prev_seg = 7'h7F;
  int         budget = 0;

  seg7_scan_reader #(.SETTLE(SETTLE), .TIMEOUT(24'(TIMEOUT))) dut (
    .clk_in(clk), .rst(rst), .seg_in(seg), .an_in(an), .value(value),
    .frame_valid(fv), .bad_pattern(bp), .multi_an_err(me), .stale(stale)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad_cnt++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic expect_ev(input int kind, input logic [15:0] v);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad_cnt++;
      $display("FAIL unexpected_event kind=%0d actual_value=%0h required=no_event", kind, v);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || (kind == K_FRAME && e.val !== v)) begin
        bad_cnt++;
        $display("FAIL event kind/value actual=%0d/%0h required=%0d/%0h", kind, v, e.kind, e.val);
      end
    end
  endtask

  // Monitor: every output pulse must match the next scoreboard entry and last one cycle
  always @(negedge clk) begin
    if (fv) begin
      n_frames++;
      last_val = value;
      expect_ev(K_FRAME, value);
      chk("frame_valid_width", 32'(fv_prev), 0);
    end
    if (bp) begin
      n_bad++;
      expect_ev(K_BAD, 16'h0);
      chk("bad_pattern_width", 32'(bp_prev), 0);
    end
    if (me) begin
      n_multi++;
      expect_ev(K_MULTI, 16'h0);
      chk("multi_an_err_width", 32'(me_prev), 0);
    end
    if (fv) stale_at_fv <= stale;
    if (fv_prev) stale_after_fv <= stale;
    fv_prev <= fv;
    bp_prev <= bp;
    me_prev <= me;
  end

  function automatic int decode(input logic [6:0] s);
    for (int i = 0; i < 16; i++) if (glyph[i] == s) return i;
    return -1;
  endfunction

  function automatic int zeros(input logic [3:0] a);
    return $countones(~a);
  endfunction

  // Drive one dwell and predict its effect from the dwell length and digit rules
  task automatic dwell(input logic [3:0] a, input logic [6:0] s, input int len);
    int d, g;
    ev_t e;
    if (zeros(a) >= 2 && zeros(m_prev_an) < 2) begin
      e.kind = K_MULTI; e.val = 16'h0; exp_q.push_back(e);
    end
    if (zeros(a) == 1 && len >= SETTLE) begin
      d = 0;
      for (int i = 0; i < 4; i++) if (!a[i]) d = i;
      g = decode(s);
      if (g >= 0) begin
        m_shadow[d] = 4'(g);
        m_seen[d] = 1'b1;
        if (m_seen[0] && m_seen[1] && m_seen[2] && m_seen[3]) begin
          e.kind = K_FRAME;
          e.val = {m_shadow[3], m_shadow[2], m_shadow[1], m_shadow[0]};
          exp_q.push_back(e);
          for (int i = 0; i < 4; i++) m_seen[i] = 1'b0;
          budget = 0;
        end
      end else begin
        m_seen[d] = 1'b0;
        e.kind = K_BAD; e.val = 16'h0; exp_q.push_back(e);
      end
    end
    m_prev_an = a;
    m_prev_seg = s;
    an = a;
    seg = s;
    repeat (len) @(negedge clk);
    budget += len;
  endtask

  task automatic go_idle();
    if (m_prev_an != 4'hF || m_prev_seg != 7'h7F) dwell(4'hF, 7'h7F, 6);
    else begin
      repeat (6) @(negedge clk);
      budget += 6;
    end
  endtask

  task automatic drain(input string name);
    int waited = 0;
    go_idle();
    while (exp_q.size() != 0 && waited < 30) begin
      @(negedge clk);
      waited++;
    end
    budget += waited;
    chk(name, 32'(exp_q.size()), 0);
  endtask

  task automatic do_reset(input int cycles);
    drain("drain_before_reset");
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_shadow[i] = 4'h0;
      m_seen[i] = 1'b0;
    end
    budget = 0;
    chk("reset_value", 32'(value), 0);
    chk("reset_frame_valid", 32'(fv), 0);
    chk("reset_bad_pattern", 32'(bp), 0);
    chk("reset_multi_an_err", 32'(me), 0);
    chk("reset_stale", 32'(stale), 0);
  endtask

  initial begin
    int f0, b0, m0, rise;
    logic [3:0] a;
    logic [6:0] s;
    int len;

    for (int i = 0; i < 4; i++) begin
      m_shadow[i] = 4'h0;
      m_seen[i] = 1'b0;
    end
    @(negedge clk);
    do_reset(3);

    // Basic frame 1,2,3,4 on digits 3..0
    f0 = n_frames; b0 = n_bad; m0 = n_multi;
    dwell(4'b0111, glyph[1], 8);
    dwell(4'b1011, glyph[2], 8);
    dwell(4'b1101, glyph[3], 8);
    dwell(4'b1110, glyph[4], 8);
    drain("drain_basic");
    chk("basic_frames", 32'(n_frames - f0), 1);
    chk("basic_value", 32'(last_val), 32'h1234);
    chk("basic_errors", 32'((n_bad - b0) + (n_multi - m0)), 0);

    // Blank glyph clears that digit's seen bit
    do_reset(1);
    f0 = n_frames; b0 = n_bad;
    dwell(4'b1110, glyph[9], 8);
    dwell(4'b1110, 7'b1111111, 8);
    chk("blank_bad_pulse", 32'(n_bad - b0), 1);
    dwell(4'b1101, glyph[3], 8);
    dwell(4'b1011, glyph[2], 8);
    dwell(4'b0111, glyph[1], 8);
    drain("drain_blank");
    chk("blank_no_frame", 32'(n_frames - f0), 0);
    dwell(4'b1110, glyph[10], 8);
    drain("drain_blank_fill");
    chk("blank_fill_frames", 32'(n_frames - f0), 1);
    chk("blank_fill_value", 32'(last_val), 32'h123A);

    // Seg bus changing faster than SETTLE never samples
    do_reset(1);
    f0 = n_frames; b0 = n_bad;
    for (int i = 0; i < 8; i++) dwell(4'b1101, glyph[(i % 2) ? 5 : 7], SETTLE - 1);
    drain("drain_fast");
    chk("fast_frames", 32'(n_frames - f0), 0);
    chk("fast_bad", 32'(n_bad - b0), 0);

    // Multi-anode keeps the seen mask
    do_reset(1);
    f0 = n_frames; m0 = n_multi;
    dwell(4'b1110, glyph[13], 8);
    dwell(4'b1101, glyph[12], 8);
    dwell(4'b0011, glyph[8], 10);
    chk("multi_pulse", 32'(n_multi - m0), 1);
    dwell(4'b1011, glyph[11], 8);
    dwell(4'b0111, glyph[14], 8);
    drain("drain_multi");
    chk("multi_frames", 32'(n_frames - f0), 1);
    chk("multi_value", 32'(last_val), 32'hEBCD);

    // Reset mid-frame discards partial data
    do_reset(1);
    dwell(4'b1110, glyph[1], 8);
    dwell(4'b1101, glyph[2], 8);
    dwell(4'b1011, glyph[3], 8);
    do_reset(1);
    f0 = n_frames;
    dwell(4'b0111, glyph[15], 8);
    dwell(4'b1011, glyph[15], 8);
    dwell(4'b1101, glyph[15], 8);
    drain("drain_rst3");
    chk("rst_three_no_frame", 32'(n_frames - f0), 0);
    dwell(4'b1110, glyph[15], 8);
    drain("drain_rst4");
    chk("rst_four_frames", 32'(n_frames - f0), 1);
    chk("rst_four_value", 32'(last_val), 32'hFFFF);

    // Staleness after TIMEOUT idle cycles, cleared by a full frame
    do_reset(1);
    rise = -1;
    for (int k = 1; k <= TIMEOUT + 20 && rise < 0; k++) begin
      @(negedge clk);
      if (stale) rise = k;
    end
    chk("stale_rise_in_window", 32'(rise >= TIMEOUT - 1 && rise <= TIMEOUT + 2), 1);
    for (int i = 0; i < 4; i++) m_seen[i] = 1'b0;
    budget = 0;
    f0 = n_frames;
    dwell(4'b0111, glyph[5], 8);
    dwell(4'b1011, glyph[6], 8);
    dwell(4'b1101, glyph[7], 8);
    dwell(4'b1110, glyph[8], 8);
    drain("drain_stale");
    chk("stale_frames", 32'(n_frames - f0), 1);
    chk("stale_value", 32'(last_val), 32'h5678);
    chk("stale_during_fv", 32'(stale_at_fv), 1);
    chk("stale_after_fv", 32'(stale_after_fv), 0);
    chk("stale_now", 32'(stale), 0);

    // Random dwells; reset before the idle budget could approach TIMEOUT
    do_reset(2);
    for (int n = 0; n < 300; n++) begin
      do begin
        case ($urandom_range(0, 7))
          0: a = 4'hF;
          1, 2: begin
            do a = 4'($urandom); while (zeros(a) < 2);
          end
          default: a = ~(4'b0001 << $urandom_range(0, 3));
        endcase
        if ($urandom_range(0, 3) == 0) s = 7'($urandom);
        else s = glyph[$urandom_range(0, 15)];
      end while (a == m_prev_an && s == m_prev_seg);
      len = ($urandom_range(0, 1) == 0) ? $urandom_range(1, SETTLE - 1)
                                        : $urandom_range(SETTLE, SETTLE + 4);
      if (budget + len + 12 > 60) do_reset(1);
      dwell(a, s, len);
    end
    drain("drain_final");
    chk("random_saw_frames", 32'(n_frames > 6), 1);

    $display("test done: total=%0d bad=%0d", total, bad_cnt);
    $finish;
  end

endmodule
